// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous signal over a gate
// window of GATE_CYCLES reference clocks and reports the count.
//
// Parameters:
//   GATE_CYCLES - gate window length in clk cycles (>= 2)
//   WIDTH       - width of the edge counter and result
//   CONTINUOUS  - 1: a new window opens immediately after each result
//
// Ports:
//   clk      - reference clock, rising edge
//   reset    - synchronous, active-high
//   sig_in   - measured signal, asynchronous to clk
//   start    - single-cycle request to open one window (ignored while busy)
//   result   - saturated edge count of the last completed window
//   valid    - one-cycle strobe when result/overflow are updated
//   busy     - high while a window is open or being closed
//   overflow - edge counter saturated during the reported window
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; edge detects discarded
// COUNT | gate open for GATE_CYCLES cycles; edge detects counted
// DONE  | one cycle; valid strobe, then IDLE (or COUNT when CONTINUOUS)

module freq_meter #(
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned WIDTH       = 32,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned     GW        = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             sync1, sync2, hist;
  logic             edge_det;
  logic [GW-1:0]    gate_cnt, gate_cnt_nxt;
  logic [WIDTH-1:0] edge_cnt, edge_cnt_nxt;
  logic             sat, sat_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             overflow_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_det = sync2 & ~hist;

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    result_nxt   = result;
    overflow_nxt = overflow;
    valid        = 1'b0;
    busy         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = COUNT;
          gate_cnt_nxt = GATE_LAST;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
        end
      end

      COUNT: begin
        busy = 1'b1;
        if (edge_det) begin
          if (edge_cnt == CNT_MAX) begin
            sat_nxt = 1'b1;
          end else begin
            edge_cnt_nxt = edge_cnt + WIDTH'(1);
          end
        end
        // Down-counter reaches zero on the last gate cycle. The result is
        // captured here, including any edge in this cycle, so it is already
        // on the output while DONE strobes valid.
        if (gate_cnt == '0) begin
          state_nxt    = DONE;
          result_nxt   = edge_cnt_nxt;
          overflow_nxt = sat_nxt;
        end else begin
          gate_cnt_nxt = gate_cnt - GW'(1);
        end
      end

      DONE: begin
        busy  = 1'b1;
        valid = 1'b1;
        if (CONTINUOUS) begin
          state_nxt    = COUNT;
          gate_cnt_nxt = GATE_LAST;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      sat      <= sat_nxt;
      result   <= result_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule
